// File: rtl/chip8_pkg.sv
// Shared types for the Chip-8 memory arbiter: bus widths, access owner and arbiter state.
package chip8_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {OWN_NONE, OWN_HOST, OWN_DATA, OWN_FETCH} owner_t;
    typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;
endpackage

// File: rtl/chip8_arb_pick.sv
// Fixed-priority winner select: host > data > fetch, or host > fetch > data when promoted.
// Purely combinational; requesters are assumed already masked by their own ack.
module chip8_arb_pick
    import chip8_pkg::*;
(
    input  logic   host_req,
    input  logic   data_req,
    input  logic   fetch_req,
    input  logic   promote,
    output owner_t winner
);

    always_comb begin
        winner = OWN_NONE;
        if (host_req)
            winner = OWN_HOST;
        else if (fetch_req && promote)
            winner = OWN_FETCH;
        else if (data_req)
            winner = OWN_DATA;
        else if (fetch_req)
            winner = OWN_FETCH;
    end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Shares the Chip-8 memory between host, CPU data and CPU fetch; grant in T, ack in T+2.
// Losers simply keep req high; a starved fetch is promoted above data after MAX_WAIT cycles.
module chip8_mem_arbiter
    import chip8_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ack,
    output logic [DATA_W-1:0] data_rdata,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic [15:0]       fetch_instr,
    output logic [ADDR_W-1:0] mem_addr1,
    output logic [ADDR_W-1:0] mem_addr2,
    output logic [DATA_W-1:0] mem_wdata1,
    output logic              mem_we1,
    input  logic [DATA_W-1:0] mem_rdata1,
    input  logic [DATA_W-1:0] mem_rdata2,
    output logic              busy
);

    arb_state_t state;
    owner_t     owner_q;
    owner_t     winner;
    owner_t     grant;
    logic       we_q;
    logic [3:0] fetch_wait;
    logic       promote;

    assign promote = (fetch_wait == 4'(MAX_WAIT));

    // Masking by the requester's own ack keeps a stale req from winning twice.
    chip8_arb_pick u_pick (
        .host_req  (host_req  & ~host_ack),
        .data_req  (data_req  & ~data_ack),
        .fetch_req (fetch_req & ~fetch_ack),
        .promote   (promote),
        .winner    (winner)
    );

    assign grant = (state == ARB_IDLE && !reset) ? winner : OWN_NONE;
    assign busy  = !reset && (state == ARB_WAIT || grant != OWN_NONE);

    always_comb begin
        mem_addr1  = '0;
        mem_addr2  = '0;
        mem_wdata1 = '0;
        mem_we1    = 1'b0;
        case (grant)
            OWN_HOST: begin
                mem_addr1  = host_addr;
                mem_we1    = host_we;
                mem_wdata1 = host_we ? host_wdata : '0;
            end
            OWN_DATA: begin
                mem_addr1  = data_addr;
                mem_we1    = data_we;
                mem_wdata1 = data_we ? data_wdata : '0;
            end
            OWN_FETCH: begin
                mem_addr1 = fetch_addr;
                mem_addr2 = fetch_addr + 12'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ARB_IDLE;
            owner_q     <= OWN_NONE;
            we_q        <= 1'b0;
            host_ack    <= 1'b0;
            data_ack    <= 1'b0;
            fetch_ack   <= 1'b0;
            host_rdata  <= '0;
            data_rdata  <= '0;
            fetch_instr <= '0;
            fetch_wait  <= '0;
        end else begin
            host_ack  <= 1'b0;
            data_ack  <= 1'b0;
            fetch_ack <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant != OWN_NONE) begin
                        state   <= ARB_WAIT;
                        owner_q <= grant;
                        we_q    <= (grant == OWN_HOST) ? host_we :
                                   (grant == OWN_DATA) ? data_we : 1'b0;
                    end
                end
                ARB_WAIT: begin
                    state   <= ARB_IDLE;
                    owner_q <= OWN_NONE;
                    case (owner_q)
                        OWN_HOST: begin
                            host_ack <= 1'b1;
                            if (!we_q) host_rdata <= mem_rdata1;
                        end
                        OWN_DATA: begin
                            data_ack <= 1'b1;
                            if (!we_q) data_rdata <= mem_rdata1;
                        end
                        OWN_FETCH: begin
                            fetch_ack   <= 1'b1;
                            fetch_instr <= {mem_rdata1, mem_rdata2};
                        end
                        default: ;
                    endcase
                end
                default: state <= ARB_IDLE;
            endcase

            if (grant == OWN_FETCH)
                fetch_wait <= '0;
            else if (fetch_req && !fetch_ack && !promote)
                fetch_wait <= fetch_wait + 4'd1;
        end
    end

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed bench for chip8_mem_arbiter with a behavioural dual-port synchronous-read memory.
module tb_chip8_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        host_req, host_we, data_req, data_we, fetch_req;
    logic [11:0] host_addr, data_addr, fetch_addr;
    logic [7:0]  host_wdata, data_wdata;
    logic        host_ack, data_ack, fetch_ack;
    logic [7:0]  host_rdata, data_rdata;
    logic [15:0] fetch_instr;
    logic [11:0] mem_addr1, mem_addr2;
    logic [7:0]  mem_wdata1;
    logic        mem_we1;
    logic [7:0]  mem_rdata1, mem_rdata2;
    logic        busy;

    logic [7:0]  mem [4096];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    chip8_mem_arbiter #(.MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .fetch_instr(fetch_instr),
        .mem_addr1(mem_addr1), .mem_addr2(mem_addr2), .mem_wdata1(mem_wdata1),
        .mem_we1(mem_we1), .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2),
        .busy(busy)
    );

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem_rdata1 = 8'h00;
        mem_rdata2 = 8'h00;
    end

    always @(posedge clk) begin
        if (mem_we1) mem[mem_addr1] <= mem_wdata1;
        mem_rdata1 <= mem[mem_addr1];
        mem_rdata2 <= mem[mem_addr2];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single host access from IDLE: grant now, ack two cycles later.
    task automatic host_op(input logic we, input logic [11:0] a, input logic [7:0] d,
                           input logic [7:0] exp_rd);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        #1;
        chk("host_grant_we", {31'd0, mem_we1}, {31'd0, we});
        chk("host_grant_addr", {20'd0, mem_addr1}, {20'd0, a});
        tick();
        chk("host_wait_we", {31'd0, mem_we1}, 32'd0);
        chk("host_wait_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("host_ack", {31'd0, host_ack}, 32'd1);
        chk("host_rdata", {24'd0, host_rdata}, {24'd0, exp_rd});
        host_req = 1'b0; host_we = 1'b0;
        tick();
        chk("host_ack_drop", {31'd0, host_ack}, 32'd0);
    endtask

    task automatic fetch_op(input logic [11:0] a, input logic [11:0] a2, input logic [15:0] exp_i);
        fetch_req = 1'b1; fetch_addr = a;
        #1;
        chk("fetch_addr1", {20'd0, mem_addr1}, {20'd0, a});
        chk("fetch_addr2", {20'd0, mem_addr2}, {20'd0, a2});
        chk("fetch_we", {31'd0, mem_we1}, 32'd0);
        tick();
        tick();
        chk("fetch_ack", {31'd0, fetch_ack}, 32'd1);
        chk("fetch_instr", {16'd0, fetch_instr}, {16'd0, exp_i});
        fetch_req = 1'b0;
        tick();
        chk("fetch_ack_drop", {31'd0, fetch_ack}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        host_req = 1'b1; data_req = 1'b1; fetch_req = 1'b1;
        host_we = 1'b0; data_we = 1'b0;
        host_addr = 12'h123; data_addr = 12'h456; fetch_addr = 12'h789;
        host_wdata = 8'h00; data_wdata = 8'h00;

        // Reset held with every requester active.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_host_ack", {31'd0, host_ack}, 32'd0);
            chk("rst_data_ack", {31'd0, data_ack}, 32'd0);
            chk("rst_fetch_ack", {31'd0, fetch_ack}, 32'd0);
            chk("rst_we", {31'd0, mem_we1}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
        end
        chk("rst_instr", {16'd0, fetch_instr}, 32'd0);
        chk("rst_addr1", {20'd0, mem_addr1}, 32'd0);

        // All three requests pending at reset release: host T, data T+2, fetch T+4.
        reset = 1'b0;
        #1;
        chk("t0_busy", {31'd0, busy}, 32'd1);
        chk("t0_host_grant", {20'd0, mem_addr1}, 32'h123);
        tick();
        chk("t1_wait_addr", {20'd0, mem_addr1}, 32'h000);
        chk("t1_host_ack", {31'd0, host_ack}, 32'd0);
        tick();
        chk("t2_host_ack", {31'd0, host_ack}, 32'd1);
        chk("t2_data_grant", {20'd0, mem_addr1}, 32'h456);
        chk("t2_data_ack", {31'd0, data_ack}, 32'd0);
        tick();
        host_req = 1'b0;
        tick();
        chk("t4_data_ack", {31'd0, data_ack}, 32'd1);
        chk("t4_fetch_addr1", {20'd0, mem_addr1}, 32'h789);
        chk("t4_fetch_addr2", {20'd0, mem_addr2}, 32'h78A);
        tick();
        data_req = 1'b0;
        tick();
        chk("t6_fetch_ack", {31'd0, fetch_ack}, 32'd1);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        tick();
        fetch_req = 1'b0;

        // Host writes then instruction fetch of the written pair.
        host_op(1'b1, 12'h200, 8'hA2, 8'h00);
        host_op(1'b1, 12'h201, 8'h1E, 8'h00);
        fetch_op(12'h200, 12'h201, 16'hA21E);
        host_op(1'b0, 12'h201, 8'h00, 8'h1E);

        // Fetch from the top of memory wraps the second byte to 0x000.
        host_op(1'b1, 12'hFFF, 8'h12, 8'h1E);
        host_op(1'b1, 12'h000, 8'h34, 8'h1E);
        fetch_op(12'hFFF, 12'h000, 16'h1234);

        // Host and data keep the memory busy; fetch waits until promoted over data.
        host_req = 1'b1; host_addr = 12'h100;
        data_req = 1'b1; data_addr = 12'h101;
        fetch_req = 1'b1; fetch_addr = 12'h102;
        #1;
        chk("s0_host", {20'd0, mem_addr1}, 32'h100);
        tick(); tick();
        chk("s2_data", {20'd0, mem_addr1}, 32'h101);
        tick(); tick();
        chk("s4_host", {20'd0, mem_addr1}, 32'h100);
        tick(); tick();
        chk("s6_data", {20'd0, mem_addr1}, 32'h101);
        tick(); tick();
        chk("s8_host", {20'd0, mem_addr1}, 32'h100);
        tick(); tick();
        chk("s10_fetch_promoted", {20'd0, mem_addr1}, 32'h102);
        chk("s10_fetch_addr2", {20'd0, mem_addr2}, 32'h103);
        chk("s10_host_ack", {31'd0, host_ack}, 32'd1);
        tick(); tick();
        chk("s12_fetch_ack", {31'd0, fetch_ack}, 32'd1);
        chk("s12_host", {20'd0, mem_addr1}, 32'h100);
        fetch_req = 1'b0;
        tick(); tick();
        chk("s14_host_ack", {31'd0, host_ack}, 32'd1);
        chk("s14_data", {20'd0, mem_addr1}, 32'h101);
        host_req = 1'b0;
        tick(); tick();
        chk("s16_data_ack", {31'd0, data_ack}, 32'd1);
        data_req = 1'b0;
        tick();
        chk("s17_busy", {31'd0, busy}, 32'd0);

        // Reset during the WAIT of a data read suppresses its ack.
        host_op(1'b1, 12'h300, 8'h5A, 8'h00);
        data_req = 1'b1; data_we = 1'b0; data_addr = 12'h300;
        #1;
        chk("r_grant", {20'd0, mem_addr1}, 32'h300);
        tick();
        reset = 1'b1; data_req = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("r_no_ack", {31'd0, data_ack}, 32'd0);
        chk("r_rdata", {24'd0, data_rdata}, 32'd0);
        chk("r_busy", {31'd0, busy}, 32'd0);
        tick();
        data_req = 1'b1;
        #1;
        chk("r2_grant", {20'd0, mem_addr1}, 32'h300);
        tick(); tick();
        chk("r2_ack", {31'd0, data_ack}, 32'd1);
        chk("r2_rdata", {24'd0, data_rdata}, 32'h5A);
        data_req = 1'b0;
        tick();
        chk("r2_busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
